// File: rtl/config_sequencer.sv
// Frames a 32-bit bitstream into address/data pairs and drives the
// array-wide configuration bus with one write strobe per pair.
module config_sequencer #(
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] tile_id,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        config_we,
   output logic        busy,
   output logic        frame_done,
   output logic [31:0] write_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_WRITE,
      S_GAP
   } state_e;

   localparam bit HasGap = (GAP_CYCLES != 0);
   localparam logic [3:0] GapInit =
      HasGap ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_e      state_q, state_d;
   logic [15:0] tile_q, tile_d;
   logic [15:0] rem_q, rem_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] wc_q, wc_d;
   logic [3:0]  gap_q, gap_d;
   logic        done_q, done_d;
   logic        accept;

   // Reset gating keeps a strobe from escaping while reset is held.
   assign in_ready = ~reset & ((state_q == S_IDLE) ||
                               (state_q == S_ADDR) ||
                               (state_q == S_DATA));
   assign config_we = ~reset & (state_q == S_WRITE);
   assign busy      = ~reset & (state_q != S_IDLE);
   assign accept    = in_valid & in_ready;

   assign tile_id     = tile_q;
   assign config_addr = addr_q;
   assign config_data = data_q;
   assign frame_done  = done_q;
   assign write_count = wc_q;

   always_comb begin
      state_d = state_q;
      tile_d  = tile_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wc_d    = wc_q;
      gap_d   = gap_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               tile_d = in_data[15:0];
               rem_d  = in_data[31:16];
               if (in_data[31:16] == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            if (accept) begin
               addr_d  = in_data;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               data_d  = in_data;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            rem_d = rem_q - 16'd1;
            wc_d  = wc_q + 32'd1;
            if (HasGap) begin
               gap_d   = GapInit;
               state_d = S_GAP;
            end else if (rem_q == 16'd1) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_ADDR;
            end
         end
         S_GAP: begin
            if (gap_q == 4'd0) begin
               if (rem_q == 16'd0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_ADDR;
               end
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         tile_q  <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wc_q    <= '0;
         gap_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tile_q  <= tile_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wc_q    <= wc_d;
         gap_q   <= gap_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: doc/config_sequencer.md
# config_sequencer

Sequences configuration writes from a 32-bit word stream onto the array-wide configuration bus shared by all PE tiles, i.e. the tile_id, config_addr and config_data inputs that every tile's address matchers, switch box and connect boxes decode. Parses framed bitstream packets and issues one write strobe per address/data pair. Holds bus values stable around each strobe and enforces a programmable gap between strobes. Sits between the bitstream loader (host or ROM reader) and the tile grid.

## Interface
Parameters:
- GAP_CYCLES, default 1: idle cycles inserted after each write strobe. Legal range 0..15.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- in_data, input, 32: bitstream word.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: the sequencer accepts a word in any cycle with in_valid && in_ready.
- tile_id, output, 16: target tile, broadcast to all tiles.
- config_addr, output, 32: configuration address, broadcast.
- config_data, output, 32: configuration data, broadcast.
- config_we, output, 1: one-cycle write strobe. Tiles latch only when it is high.
- busy, output, 1: high whenever state ≠ IDLE.
- frame_done, output, 1: one-cycle pulse when a frame completes.
- write_count, output, 32: total strobes issued since reset. Wraps modulo 2^32.

## Operation
Frame format, in word order:
- Header: bits [15:0] are tile_id; bits [31:16] are N, the pair count.
- Then N pairs, each an address word followed by a data word.

State machine:
- IDLE: in_ready=1. On accept, latch tile_id and remaining=N.
  - If N==0: pulse frame_done next cycle and stay in IDLE.
  - Otherwise go to ADDR.
- ADDR: in_ready=1. On accept, latch config_addr and go to DATA.
- DATA: in_ready=1. On accept, latch config_data and go to WRITE.
- WRITE: in_ready=0 and config_we=1 for exactly one cycle. remaining decrements and write_count increments.
  - If GAP_CYCLES>0, go to GAP.
  - Else if remaining (after decrement) is 0, go to IDLE and pulse frame_done.
  - Else go to ADDR.
- GAP: in_ready=0. Counts GAP_CYCLES cycles, then goes to ADDR, or to IDLE with a frame_done pulse if remaining==0.

Output behaviour:
- tile_id, config_addr and config_data change only on word accept. They hold their last values at all other times, including in IDLE, so the bus stays stable during and after each strobe.
- in_valid low in ADDR or DATA stalls the machine in place indefinitely, with no timeout.
- The remaining counter is 16 bits. N=65535 must complete with 65535 strobes.

Reset:
- All outputs go to 0: tile_id, config_addr, config_data, config_we, busy, frame_done, write_count. in_ready is 0 during the reset cycle and 1 from the first cycle after reset deasserts. State goes to IDLE, remaining to 0, and the gap counter to 0.
- Reset mid-frame discards the partial frame without a strobe, even if it arrives in the WRITE cycle. The next accepted word is treated as a header.

## Timing
- in_ready is a registered state decode. It has no combinational path from in_valid.
- Data word accepted in cycle t: config_we=1 in cycle t+1, with config_addr and config_data already valid in t+1.
- Next address word accepted no earlier than cycle t+2+GAP_CYCLES.
- Throughput with continuous in_valid is one strobe per 3+GAP_CYCLES cycles.
- frame_done asserts in the cycle after the final WRITE (GAP_CYCLES=0) or after the final GAP cycle, and in IDLE is already able to accept the next header in that same cycle. For N==0 it asserts the cycle after the header is accepted.
- write_count is updated on the edge ending WRITE and reads the new value in the following cycle.

## Test plan
- Reset: hold reset 3 cycles mid-stream. Required: all outputs 0 and in_ready 0 during reset; in_ready=1 the cycle after.
- Single frame, GAP_CYCLES=1, continuous valid. Stream 0x0002_0005, 0x10, 0xAA, 0x11, 0xBB.
  - Required: two strobes with (tile_id=5, addr=0x10, data=0xAA), then (5, 0x11, 0xBB), spaced 4 cycles apart.
  - Required: frame_done 2 cycles after the second strobe; write_count=2.
- Zero-length frame: header 0x0000_0007. Required: no config_we, frame_done one cycle later, tile_id=7.
- Back-to-back frames, GAP_CYCLES=0:
  - Frame A: header 0x0001_0003, then 0x1, 0x2.
  - Frame B: header 0x0001_0004, then 0x3, 0x4.
  - Required: strobes (3,1,2) and (4,3,4); the header for B is accepted in the cycle frame_done pulses.
- Stall: drop in_valid for 10 cycles between the address and data words. Required: no strobe and bus outputs unchanged during the stall; the strobe fires the cycle after the data is accepted.
- Reset in the WRITE cycle and during GAP:
  - Required: no strobe on reset during WRITE. A write_count increment is suppressed only when reset arrives in the WRITE cycle (write_count is cleared to 0 by reset in either case).
  - Required: following the reset, the next frame is parsed from its header correctly.
